// File: rtl/control_multiciclo.sv
// Multicycle control sequencer for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
module control_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       salto,
    input  logic       mem_listo,
    output logic [1:0] modo,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic       sel_pc,
    output logic       sel_dir,
    output logic [1:0] sel_res,
    output logic       lee_mem,
    output logic       esc_mem,
    output logic       esc_ir,
    output logic       esc_pc,
    output logic       esc_reg,
    output logic       instr_fin,
    output logic       error
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    // Moore part of the outputs plus flags marking the states whose outputs
    // also depend on mem_listo or salto in the current cycle.
    typedef struct packed {
        logic [1:0] modo;
        logic [1:0] selA;
        logic [1:0] selB;
        logic       selPc;
        logic       selDir;
        logic [1:0] selRes;
        logic       leeMem;
        logic       escMem;
        logic       escPc;
        logic       escReg;
        logic       instrFin;
        logic       error;
        logic       inFetch;
        logic       inMemWr;
        logic       inBranch;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    function automatic ctrl_t decodeState(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.leeMem  = 1'b1;
                c.selB    = 2'b10;
                c.inFetch = 1'b1;
            end
            S_DECODE: begin
                c.selA = 2'b10;
                c.selB = 2'b01;
            end
            S_EXEC_R: begin
                c.selA = 2'b01;
                c.selB = 2'b00;
                c.modo = 2'b10;
            end
            S_EXEC_I: begin
                c.selA = 2'b01;
                c.selB = 2'b01;
                c.modo = 2'b01;
            end
            S_ADDR: begin
                c.selA = 2'b01;
                c.selB = 2'b01;
            end
            S_MEM_RD: begin
                c.selDir = 1'b1;
                c.leeMem = 1'b1;
            end
            S_MEM_WR: begin
                c.selDir  = 1'b1;
                c.escMem  = 1'b1;
                c.inMemWr = 1'b1;
            end
            S_WB_ALU: begin
                c.escReg   = 1'b1;
                c.instrFin = 1'b1;
            end
            S_WB_MEM: begin
                c.escReg   = 1'b1;
                c.selRes   = 2'b01;
                c.instrFin = 1'b1;
            end
            S_BRANCH: begin
                c.selA     = 2'b01;
                c.modo     = 2'b11;
                c.selPc    = 1'b1;
                c.instrFin = 1'b1;
                c.inBranch = 1'b1;
            end
            S_JAL: begin
                c.escReg   = 1'b1;
                c.selRes   = 2'b10;
                c.escPc    = 1'b1;
                c.selPc    = 1'b1;
                c.instrFin = 1'b1;
            end
            S_JALR: begin
                c.selA     = 2'b01;
                c.selB     = 2'b01;
                c.escPc    = 1'b1;
                c.escReg   = 1'b1;
                c.selRes   = 2'b10;
                c.instrFin = 1'b1;
            end
            S_LUI: begin
                c.escReg   = 1'b1;
                c.selRes   = 2'b11;
                c.instrFin = 1'b1;
            end
            S_AUIPC: begin
                c.escReg   = 1'b1;
                c.instrFin = 1'b1;
            end
            S_TRAP: begin
                c.error = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = mem_listo ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    OP_JALR:            state_d = S_JALR;
                    OP_LUI:             state_d = S_LUI;
                    OP_AUIPC:           state_d = S_AUIPC;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = mem_listo ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: state_d = mem_listo ? S_FETCH : S_MEM_WR;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC:
                      state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= decodeState(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decodeState(state_d);
        end
    end

    // Reset forces every output low in the cycle it is asserted, so a pending
    // memory request or write never survives into the reset cycle.
    always_comb begin
        modo      = reset ? 2'b00 : ctrl_q.modo;
        sel_a     = reset ? 2'b00 : ctrl_q.selA;
        sel_b     = reset ? 2'b00 : ctrl_q.selB;
        sel_pc    = !reset && ctrl_q.selPc;
        sel_dir   = !reset && ctrl_q.selDir;
        sel_res   = reset ? 2'b00 : ctrl_q.selRes;
        lee_mem   = !reset && ctrl_q.leeMem;
        esc_mem   = !reset && ctrl_q.escMem;
        esc_reg   = !reset && ctrl_q.escReg;
        error     = !reset && ctrl_q.error;
        esc_ir    = !reset && ctrl_q.inFetch && mem_listo;
        esc_pc    = !reset && (ctrl_q.escPc
                               || (ctrl_q.inFetch && mem_listo)
                               || (ctrl_q.inBranch && salto));
        instr_fin = !reset && (ctrl_q.instrFin || (ctrl_q.inMemWr && mem_listo));
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo: an instruction-level model expands each
// instruction into its expected per-cycle control vector, compared against the DUT.
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'h00;
    logic       salto = 1'b0;
    logic       mem_listo = 1'b0;
    logic [1:0] modo, sel_a, sel_b, sel_res;
    logic       sel_pc, sel_dir, lee_mem, esc_mem, esc_ir, esc_pc, esc_reg, instr_fin, error;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_BAD    = 7'h7F;

    typedef struct packed {
        logic [1:0] modo;
        logic [1:0] selA;
        logic [1:0] selB;
        logic       selPc;
        logic       selDir;
        logic [1:0] selRes;
        logic       lee;
        logic       escMem;
        logic       escIr;
        logic       escPc;
        logic       escReg;
        logic       fin;
        logic       err;
    } outs_t;

    outs_t      obs;
    outs_t      expQ[$];
    logic       listoQ[$];
    logic       saltoQ[$];
    logic [6:0] opQ[$];
    int         testsRun = 0;
    int         testsFailed = 0;

    control_multiciclo dut (
        .clk(clk), .reset(reset), .op(op), .salto(salto), .mem_listo(mem_listo),
        .modo(modo), .sel_a(sel_a), .sel_b(sel_b), .sel_pc(sel_pc), .sel_dir(sel_dir),
        .sel_res(sel_res), .lee_mem(lee_mem), .esc_mem(esc_mem), .esc_ir(esc_ir),
        .esc_pc(esc_pc), .esc_reg(esc_reg), .instr_fin(instr_fin), .error(error)
    );

    always #5 clk = ~clk;

    always_comb obs = {modo, sel_a, sel_b, sel_pc, sel_dir, sel_res,
                       lee_mem, esc_mem, esc_ir, esc_pc, esc_reg, instr_fin, error};

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void pushCycle(outs_t c, logic l, logic s, logic [6:0] o);
        expQ.push_back(c);
        listoQ.push_back(l);
        saltoQ.push_back(s);
        opQ.push_back(o);
    endfunction

    // Instruction-level model: w1 fetch wait cycles, w2 memory wait cycles.
    // mem_listo and salto are randomised wherever they must be ignored.
    function automatic void addInstr(logic [6:0] o, logic s, int w1, int w2, int trapCycles);
        outs_t c;
        for (int i = 0; i < w1; i++) begin
            c = '0; c.lee = 1'b1; c.selB = 2'b10;
            pushCycle(c, 1'b0, 1'($urandom), o);
        end
        c = '0; c.lee = 1'b1; c.selB = 2'b10; c.escIr = 1'b1; c.escPc = 1'b1;
        pushCycle(c, 1'b1, 1'($urandom), o);
        c = '0; c.selA = 2'b10; c.selB = 2'b01;
        pushCycle(c, 1'($urandom), 1'($urandom), o);
        case (o)
            OP_R, OP_I: begin
                c = '0; c.selA = 2'b01;
                c.selB = (o == OP_R) ? 2'b00 : 2'b01;
                c.modo = (o == OP_R) ? 2'b10 : 2'b01;
                pushCycle(c, 1'($urandom), 1'($urandom), o);
                c = '0; c.escReg = 1'b1; c.fin = 1'b1;
                pushCycle(c, 1'($urandom), 1'($urandom), o);
            end
            OP_LOAD, OP_STORE: begin
                c = '0; c.selA = 2'b01; c.selB = 2'b01;
                pushCycle(c, 1'($urandom), 1'($urandom), o);
                c = '0; c.selDir = 1'b1;
                if (o == OP_LOAD) c.lee = 1'b1; else c.escMem = 1'b1;
                for (int i = 0; i < w2; i++) pushCycle(c, 1'b0, 1'($urandom), o);
                if (o == OP_STORE) c.fin = 1'b1;
                pushCycle(c, 1'b1, 1'($urandom), o);
                if (o == OP_LOAD) begin
                    c = '0; c.escReg = 1'b1; c.selRes = 2'b01; c.fin = 1'b1;
                    pushCycle(c, 1'($urandom), 1'($urandom), o);
                end
            end
            OP_BRANCH: begin
                c = '0; c.selA = 2'b01; c.modo = 2'b11; c.selPc = 1'b1;
                c.escPc = s; c.fin = 1'b1;
                pushCycle(c, 1'($urandom), s, o);
            end
            OP_JAL: begin
                c = '0; c.escReg = 1'b1; c.selRes = 2'b10; c.escPc = 1'b1;
                c.selPc = 1'b1; c.fin = 1'b1;
                pushCycle(c, 1'($urandom), 1'($urandom), o);
            end
            OP_JALR: begin
                c = '0; c.selA = 2'b01; c.selB = 2'b01; c.escPc = 1'b1;
                c.escReg = 1'b1; c.selRes = 2'b10; c.fin = 1'b1;
                pushCycle(c, 1'($urandom), 1'($urandom), o);
            end
            OP_LUI, OP_AUIPC: begin
                c = '0; c.escReg = 1'b1; c.fin = 1'b1;
                c.selRes = (o == OP_LUI) ? 2'b11 : 2'b00;
                pushCycle(c, 1'($urandom), 1'($urandom), o);
            end
            default: begin
                c = '0; c.err = 1'b1;
                for (int i = 0; i < trapCycles; i++)
                    pushCycle(c, 1'($urandom), 1'($urandom), o);
            end
        endcase
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1; mem_listo = 1'($urandom); salto = 1'($urandom); op = 7'($urandom);
            #1;
            testsRun++;
            if (obs !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", i, obs);
            end
        end
    endtask

    task automatic test_classes();
        outs_t e;
        int n = 0;
        logic [6:0] ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        foreach (ops[k]) addInstr(ops[k], 1'b1, 0, 0, 0);
        while (expQ.size() > 0) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL classes cycle %0d: got %h expected %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_mem_waits();
        outs_t e;
        int n = 0;
        addInstr(OP_LOAD, 1'b0, 2, 2, 0);
        addInstr(OP_STORE, 1'b0, 1, 3, 0);
        addInstr(OP_R, 1'b0, 3, 0, 0);
        while (expQ.size() > 0) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL mem_waits cycle %0d: got %h expected %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        outs_t e;
        int n = 0;
        addInstr(OP_BRANCH, 1'b1, 0, 0, 0);
        addInstr(OP_BRANCH, 1'b0, 0, 0, 0);
        addInstr(OP_BRANCH, 1'b0, 1, 0, 0);
        addInstr(OP_BRANCH, 1'b1, 2, 0, 0);
        while (expQ.size() > 0) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL branch cycle %0d: got %h expected %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_random();
        outs_t e;
        int n = 0;
        logic [6:0] ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        for (int k = 0; k < 40; k++)
            addInstr(ops[$urandom_range(0, 8)], 1'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 2), 0);
        while (expQ.size() > 0) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_trap();
        outs_t e;
        int n = 0;
        addInstr(OP_BAD, 1'b0, 1, 0, 20);
        while (expQ.size() > 0) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL trap cycle %0d: got %h expected %h", n, obs, e);
            end
            n++;
        end
        @(negedge clk);
        reset = 1'b1; mem_listo = 1'b1;
        #1;
        testsRun++;
        if (obs !== '0) begin
            testsFailed++;
            $display("[TB] FAIL trap_reset: got %h expected 0", obs);
        end
        addInstr(OP_R, 1'b0, 0, 0, 0);
        while (expQ.size() > 0) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL trap_resume cycle %0d: got %h expected %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        outs_t e;
        int n = 0;
        addInstr(OP_LOAD, 1'b0, 0, 5, 0);
        // Run fetch, decode, addr and two memory wait cycles, then abort.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_pre cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        expQ.delete(); listoQ.delete(); saltoQ.delete(); opQ.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1; mem_listo = 1'b1;
            #1;
            testsRun++;
            if (obs !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_abort cycle %0d: got %h expected 0", i, obs);
            end
        end
        addInstr(OP_I, 1'b0, 1, 0, 0);
        while (expQ.size() > 0) begin
            @(negedge clk);
            reset = 1'b0; mem_listo = listoQ.pop_front(); salto = saltoQ.pop_front();
            op = opQ.pop_front(); e = expQ.pop_front();
            #1;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_resume cycle %0d: got %h expected %h", n, obs, e);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_classes();
        test_mem_waits();
        test_branch();
        test_trap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle sequencer for the RV32I core. It is a Moore/Mealy FSM that reads the opcode held in the instruction register and drives every datapath enable and mux select. It supplies `modo` to `control_alu`, which decodes `funct3`/`funct7` into `sel_alu`. It also handles the memory ready handshake for fetch, load and store.

## Interface
Parameters:
- none (RV32I opcodes fixed)

Ports:
- clk  in  1  core clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- op  in  7  opcode field of instruction register (`ir[6:0]`)
- salto  in  1  branch condition from ALU in modo 11 (1 = taken)
- mem_listo  in  1  memory ready; transfer completes in a cycle where it is 1
- modo  out  2  to control_alu: 00 add, 01 type-19, 10 type-51, 11 branch compare
- sel_a  out  2  ALU A: 00 PC, 01 rs1, 10 pc_ant (PC of current instruction)
- sel_b  out  2  ALU B: 00 rs2, 01 imm, 10 constant 4
- sel_pc  out  1  PC source: 0 ALU result (comb.), 1 alu_out register
- sel_dir  out  1  memory address: 0 PC, 1 alu_out register
- sel_res  out  2  rd data: 00 alu_out reg, 01 mem data reg, 10 PC, 11 imm
- lee_mem  out  1  memory read request
- esc_mem  out  1  memory write request
- esc_ir  out  1  load IR and pc_ant<=PC
- esc_pc  out  1  PC write enable
- esc_reg  out  1  register file write enable
- instr_fin  out  1  one-cycle pulse when an instruction retires
- error  out  1  sticky: illegal opcode trapped

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, AUIPC, TRAP. Encoding is free.
- Unlisted outputs are 0 in every state.
- FETCH: sel_dir=0, lee_mem=1, sel_a=00, sel_b=10, modo=00.
  - mem_listo=0: stay in FETCH.
  - mem_listo=1 (Mealy): esc_ir=1, esc_pc=1, sel_pc=0 (PC<=PC+4), go to DECODE.
- DECODE: sel_a=10, sel_b=01, modo=00, so alu_out<=pc_ant+imm. Dispatch on op:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other → TRAP
- EXEC_R: sel_a=01, sel_b=00, modo=10 → WB_ALU.
- EXEC_I: sel_a=01, sel_b=01, modo=01 → WB_ALU.
- WB_ALU: esc_reg=1, sel_res=00, instr_fin=1 → FETCH.
- ADDR: sel_a=01, sel_b=01, modo=00. Next state is MEM_RD if op=0000011, else MEM_WR.
- MEM_RD: sel_dir=1, lee_mem=1. Wait for mem_listo; the datapath latches read data. Then → WB_MEM.
- WB_MEM: esc_reg=1, sel_res=01, instr_fin=1 → FETCH.
- MEM_WR: sel_dir=1, esc_mem=1. Wait for mem_listo; on completion instr_fin=1 → FETCH.
- BRANCH: sel_a=01, sel_b=00, modo=11, sel_pc=1, esc_pc=salto (Mealy), instr_fin=1 → FETCH.
- JAL: esc_reg=1, sel_res=10 (PC already holds pc_ant+4), esc_pc=1, sel_pc=1, instr_fin=1 → FETCH.
- JALR: sel_a=01, sel_b=01, modo=00, esc_pc=1, sel_pc=0, esc_reg=1, sel_res=10, instr_fin=1 → FETCH. Clearing bit 0 of the target is the datapath's job.
- LUI: esc_reg=1, sel_res=11, instr_fin=1 → FETCH.
- AUIPC: esc_reg=1, sel_res=00, instr_fin=1 → FETCH.
- TRAP: error=1, all enables 0. Stays in TRAP until reset.

## Timing
- While reset=1, all outputs are 0, including lee_mem and error. The next state is FETCH. The first fetch request appears in the first cycle after reset falls.
- Reset mid-instruction aborts it. Any pending memory request drops in the cycle after reset is sampled, and no partial write is issued.
- mem_listo is sampled only in FETCH, MEM_RD and MEM_WR and is ignored elsewhere. While waiting, the request line and all selects are held stable.
- Latency with mem_listo=1 on first request:
  - R / I / store: 4 cycles
  - load: 5 cycles
  - branch / JAL / JALR / LUI / AUIPC: 3 cycles
  - each wait cycle adds 1
- instr_fin is exactly 1 cycle per retired instruction. It is never asserted in FETCH, DECODE or TRAP.
- Register and PC writes take effect on the rising edge that ends the asserting cycle. JAL and JALR read the old PC in the same cycle they overwrite it.

## Test plan
- ADD, mem_listo tied 1: op=0110011 → states FETCH, DECODE, EXEC_R, WB_ALU. modo=10 in EXEC_R, esc_reg=1 at cycle 4, instr_fin pulses once.
- LW with mem_listo low for 2 cycles in both FETCH and MEM_RD → 9 cycles total. lee_mem and sel_dir are stable across waits; esc_reg=1 only in WB_MEM with sel_res=01.
- BEQ: salto=1 → esc_pc=1, sel_pc=1 in cycle 3. Repeat with salto=0 → esc_pc=0; both retire in 3 cycles.
- JALR: esc_pc=1, sel_pc=0, esc_reg=1, sel_res=10 in the same cycle. SW: esc_mem=1 only in MEM_WR, sel_dir=1, 4 cycles.
- op=1111111 → TRAP after DECODE. error=1 stays high for 20 cycles, no enables. Reset clears error and fetch resumes.
- Assert reset during MEM_RD wait → next cycle lee_mem=0 and all enables 0. After release, FETCH with lee_mem=1, sel_dir=0.
